smult_8bit: RTL and testbench

SMULT_8BIT -- requirements
Module: smult_8bit

---
 rtl/smult_8bit_pkg.sv | 12 +
 rtl/smult_8bit_if.sv | 14 +
 rtl/smult_8bit_full_adder.sv | 15 +
 rtl/smult_8bit.sv | 127 ++++++++++++
 tb/tb_smult_8bit.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/smult_8bit_pkg.sv
// Shared widths and types for the signed 8x8 multiplier slice.
// Latency: n/a (constants and typedefs only).
// Backpressure: n/a; the multiplier has no handshake.
package smult_8bit_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/smult_8bit_if.sv
// Operand/product bundle between the multiplier and whoever feeds it.
// Latency: n/a (wires only).
// Backpressure: none; operands are consumed every cycle.
interface smult_8bit_if;
    import smult_8bit_pkg::*;

    op_t   a;
    op_t   b;
    prod_t p;

    modport master (output a, output b, input p);
    modport slave  (input a, input b, output p);

endinterface

// File: rtl/smult_8bit_full_adder.sv
// One-bit full adder; the building cell of the carry-save and ripple rows.
// Latency: combinational.
// Backpressure: n/a.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/smult_8bit.sv
// Signed 8x8 Baugh-Wooley array multiplier with a registered 16-bit product.
// Latency: 1 cycle (operands are unregistered, the product is captured every edge).
// Backpressure: none; one product per cycle, no enable or valid.
module smult_8bit
    import smult_8bit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    smult_8bit_if.slave bus
);

    localparam int LAST = OP_W - 1;

    // pp[i][j] is the partial product of a[i] and b[j], weight i+j.
    // s[j][i] has weight i+j; c[j][i] has weight i+j+1.
    logic            pp [OP_W][OP_W];
    logic            s  [OP_W][OP_W];
    logic            c  [OP_W][OP_W];
    logic [OP_W-1:0] rs;
    logic [OP_W-2:0] rc;
    logic            carry_unused;
    prod_t           prod;
    prod_t           prod_q;

    genvar i, j;

    // Partial products: cells with exactly one sign bit are inverted (NAND).
    generate
        for (i = 0; i < OP_W; i++) begin : g_pp_i
            for (j = 0; j < OP_W; j++) begin : g_pp_j
                if ((i == LAST) != (j == LAST)) begin : g_nand
                    assign pp[i][j] = ~(bus.a[i] & bus.b[j]);
                end else begin : g_and
                    assign pp[i][j] = bus.a[i] & bus.b[j];
                end
            end
        end
    endgenerate

    // Row 0 is just the first partial-product row with no carries yet.
    generate
        for (i = 0; i < OP_W; i++) begin : g_row0
            assign s[0][i] = pp[i][0];
            assign c[0][i] = 1'b0;
        end
    endgenerate

    // Carry-save rows: each cell adds its partial product to the shifted
    // sum and the unshifted carry of the row above.
    generate
        for (j = 1; j < OP_W; j++) begin : g_csa_row
            for (i = 0; i < OP_W; i++) begin : g_csa_cell
                logic s_in;
                if (i < LAST) begin : g_mid
                    assign s_in = s[j-1][i+1];
                end else begin : g_top
                    assign s_in = 1'b0;
                end
                full_adder u_fa (
                    .a    (pp[i][j]),
                    .b    (s_in),
                    .cin  (c[j-1][i]),
                    .sum  (s[j][i]),
                    .cout (c[j][i])
                );
            end
        end
    endgenerate

    // Final ripple row over bits 8..15; the two Baugh-Wooley '1's enter as
    // the carry-in of bit 8 and the otherwise free sum input of bit 15.
    generate
        for (i = 0; i < OP_W; i++) begin : g_ripple
            logic fa_a;
            logic fa_cin;
            if (i < LAST) begin : g_a_sum
                assign fa_a = s[LAST][i+1];
            end else begin : g_a_corr
                assign fa_a = 1'b1;
            end
            if (i == 0) begin : g_cin_corr
                assign fa_cin = 1'b1;
            end else begin : g_cin_chain
                assign fa_cin = rc[i-1];
            end
            if (i < LAST) begin : g_co_chain
                full_adder u_fa (
                    .a    (fa_a),
                    .b    (c[LAST][i]),
                    .cin  (fa_cin),
                    .sum  (rs[i]),
                    .cout (rc[i])
                );
            end else begin : g_co_drop
                // Carry out of bit 15 is the modulo-2^16 overflow of the
                // correction terms and carries no information.
                full_adder u_fa (
                    .a    (fa_a),
                    .b    (c[LAST][i]),
                    .cin  (fa_cin),
                    .sum  (rs[i]),
                    .cout (carry_unused)
                );
            end
        end
    endgenerate

    // Low product bits fall out of the array's right edge, one per row.
    generate
        for (j = 0; j < OP_W; j++) begin : g_low
            assign prod[j] = s[j][0];
        end
    endgenerate
    assign prod[PROD_W-1:OP_W] = rs;

    // Product register: cleared asynchronously, loaded every rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod;
        end
    end

    assign bus.p = prod_q;

endmodule

// File: tb/tb_smult_8bit.sv
// Scoreboard bench for smult_8bit: directed, random and exhaustive operands.
// Latency: expects each product one rising edge after the operands are driven.
// Backpressure: none; one operand pair is issued per cycle.
module tb_smult_8bit;
    import smult_8bit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    smult_8bit_if bus();

    smult_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: p=0x%04h required 0x%04h", name, got, exp);
        end
    endtask

    // Reference: plain signed integer multiply, reduced to 16 bits.
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        int r;
        sx = $signed(x);
        sy = $signed(y);
        r  = sx * sy;
        return r[15:0];
    endfunction

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        txn_t t;
        @(negedge clk);
        bus.a = x;
        bus.b = y;
        t.a   = x;
        t.b   = y;
        t.exp = e;
        sb.push_back(t);
    endtask

    // Monitor: the product register updates every edge, so one entry is
    // retired after each edge whenever one is outstanding.
    initial begin
        txn_t t;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                t = sb.pop_front();
                check($sformatf("mul a=%02h b=%02h", t.a, t.b), bus.p, t.exp);
            end
        end
    end

    // {a, b, expected p}
    logic [31:0] directed [] = '{
        32'h99_01_FF99, 32'h7E_FF_FF82, 32'hF5_78_FAD8, 32'h81_81_3F01,
        32'h80_80_4000, 32'h80_7F_C080, 32'hA6_5A_E05C, 32'h7A_39_1B2A,
        32'h7D_8F_C8D3, 32'hA5_39_EBBD, 32'h4C_A5_E4FC, 32'h00_80_0000,
        32'h80_00_0000, 32'h00_FF_0000, 32'hFF_00_0000, 32'h80_01_FF80,
        32'h80_FF_0080, 32'h7F_FF_FF81, 32'h01_80_FF80, 32'h7F_7F_3F01
    };

    initial begin
        txn_t t;
        logic [31:0] v;
        logic [7:0]  x;
        logic [7:0]  y;

        bus.a = 8'h00;
        bus.b = 8'h00;
        #1 rst = 1'b1;
        #1 check("reset async", bus.p, 16'h0000);

        bus.a = 8'h7F;
        bus.b = 8'h7F;
        repeat (2) @(posedge clk);
        #1 check("reset held over edges", bus.p, 16'h0000);

        // First edge after release loads the operands already present.
        @(negedge clk);
        rst   = 1'b0;
        t.a   = 8'h7F;
        t.b   = 8'h7F;
        t.exp = 16'h3F01;
        sb.push_back(t);

        foreach (directed[k]) begin
            v = directed[k];
            issue(v[31:24], v[23:16], v[15:0]);
        end

        // Mid-cycle operand change must not reach p before the next edge,
        // and a reset between edges must clear p at once.
        issue(8'h7A, 8'h39, 16'h1B2A);
        @(posedge clk);
        #2;
        bus.a = 8'h11;
        bus.b = 8'h22;
        #1 check("hold between edges", bus.p, 16'h1B2A);
        rst = 1'b1;
        #1 check("reset mid cycle", bus.p, 16'h0000);
        @(posedge clk);
        #1 check("reset discards pending", bus.p, 16'h0000);
        bus.a = 8'h7D;
        bus.b = 8'h8F;
        @(negedge clk);
        rst = 1'b0;
        #1 check("released before edge", bus.p, 16'h0000);
        t.a   = 8'h7D;
        t.b   = 8'h8F;
        t.exp = 16'hC8D3;
        sb.push_back(t);

        for (int n = 0; n < 2000; n++) begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            issue(x, y, ref_mul(x, y));
        end

        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                x = 8'(ai);
                y = 8'(bi);
                issue(x, y, ref_mul(x, y));
            end
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d products outstanding, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
